// File: rtl/disp_hole_filler_if.sv
// disp_hole_filler_if: pixel stream in, filtered stream out, with valid/ready on both sides.
interface disp_hole_filler_if #(
    parameter int disp_bits = 5
);
    logic [disp_bits+7:0] disp_conf_in;
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           conf_thresh;
    logic [disp_bits-1:0] disp_out;
    logic                 filled_out;
    logic                 sof_out;
    logic                 eol_out;
    logic                 out_valid;
    logic                 out_ready;

    modport slave (
        input  disp_conf_in, in_valid, conf_thresh, out_ready,
        output in_ready, disp_out, filled_out, sof_out, eol_out, out_valid
    );

    modport master (
        output disp_conf_in, in_valid, conf_thresh, out_ready,
        input  in_ready, disp_out, filled_out, sof_out, eol_out, out_valid
    );
endinterface

// File: rtl/disp_hole_filler.sv
// disp_hole_filler: confidence threshold, left-to-right hole fill and frame markers, one register stage.
// Define DISP_HOLE_FILL_EN to build the hold/fill logic; otherwise low-confidence pixels output 0.
module disp_hole_filler #(
    parameter int disp_bits        = 5,
    parameter int dec_frame_width  = 240,
    parameter int dec_frame_height = 135,
    parameter int max_hold         = 8
) (
    input logic clk,
    input logic reset,
    disp_hole_filler_if.slave s
);
    localparam int cw = $clog2(dec_frame_width);
    localparam int rw = $clog2(dec_frame_height);

    logic [cw-1:0]        col_q, col_d;
    logic [rw-1:0]        row_q, row_d;
    logic [7:0]           thresh_q, thresh_d, thr, conf;
    logic [disp_bits-1:0] disp, disp_q, disp_d, px_disp;
    logic valid_q, valid_d, filled_q, filled_d, sof_q, sof_d, eol_q, eol_d;
    logic acc, first, col_last, row_last, good, px_fill;

    assign conf       = s.disp_conf_in[7:0];
    assign disp       = s.disp_conf_in[disp_bits+7:8];
    assign s.in_ready = !valid_q || s.out_ready;
    assign acc        = s.in_valid && s.in_ready;
    assign s.out_valid  = valid_q;
    assign s.disp_out   = disp_q;
    assign s.filled_out = filled_q;
    assign s.sof_out    = sof_q;
    assign s.eol_out    = eol_q;

    always_comb begin
        first    = col_q == '0 && row_q == '0;
        thr      = first ? s.conf_thresh : thresh_q;
        good     = conf >= thr;
        col_last = col_q == cw'(dec_frame_width - 1);
        row_last = row_q == rw'(dec_frame_height - 1);
        col_d    = acc ? (col_last ? '0 : col_q + cw'(1)) : col_q;
        row_d    = acc && col_last ? (row_last ? '0 : row_q + rw'(1)) : row_q;
        thresh_d = acc && first ? s.conf_thresh : thresh_q;
        valid_d  = acc ? 1'b1 : (s.out_ready ? 1'b0 : valid_q);
        disp_d   = acc ? px_disp : disp_q;
        filled_d = acc ? px_fill : filled_q;
        sof_d    = acc ? first : sof_q;
        eol_d    = acc ? col_last : eol_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q    <= '0;
            row_q    <= '0;
            thresh_q <= '0;
            valid_q  <= 1'b0;
            disp_q   <= '0;
            filled_q <= 1'b0;
            sof_q    <= 1'b0;
            eol_q    <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            thresh_q <= thresh_d;
            valid_q  <= valid_d;
            disp_q   <= disp_d;
            filled_q <= filled_d;
            sof_q    <= sof_d;
            eol_q    <= eol_d;
        end
    end

`ifdef DISP_HOLE_FILL_EN
    localparam int hw = max_hold > 0 ? $clog2(max_hold + 1) : 1;

    logic [disp_bits-1:0] last_good_q, last_good_d;
    logic [hw-1:0]        hold_cnt_q, hold_cnt_d;
    logic                 hold_valid_q, hold_valid_d, fill;

    // A hold never crosses a row boundary: column 0 ignores any held value.
    always_comb begin
        fill         = !good && hold_valid_q && col_q != '0 && hold_cnt_q < hw'(max_hold);
        px_disp      = good ? disp : (fill ? last_good_q : '0);
        px_fill      = fill;
        last_good_d  = acc && good ? disp : last_good_q;
        hold_valid_d = acc ? (good || fill) : hold_valid_q;
        hold_cnt_d   = !acc ? hold_cnt_q : (good ? '0 : (fill ? hold_cnt_q + hw'(1) : hold_cnt_q));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_good_q  <= '0;
            hold_valid_q <= 1'b0;
            hold_cnt_q   <= '0;
        end else begin
            last_good_q  <= last_good_d;
            hold_valid_q <= hold_valid_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end
`else
    assign px_disp = good ? disp : '0;
    assign px_fill = 1'b0;
`endif
endmodule

// File: tb/tb_disp_hole_filler.sv
// tb_disp_hole_filler: directed checks of threshold, fill, markers, backpressure and reset.
module tb_disp_hole_filler;
`ifdef DISP_HOLE_FILL_EN
    localparam bit fill_en = 1'b1;
`else
    localparam bit fill_en = 1'b0;
`endif
    localparam int frame_words = 240 * 135;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    disp_hole_filler_if #(.disp_bits(5)) ifc ();
    disp_hole_filler_if #(.disp_bits(5)) ifc0 ();

    assign ifc0.disp_conf_in = ifc.disp_conf_in;
    assign ifc0.in_valid     = ifc.in_valid;
    assign ifc0.conf_thresh  = ifc.conf_thresh;
    assign ifc0.out_ready    = ifc.out_ready;

    disp_hole_filler #(.disp_bits(5), .dec_frame_width(240), .dec_frame_height(135), .max_hold(8)) u_dut (
        .clk(clk), .reset(reset), .s(ifc.slave));

    disp_hole_filler #(.disp_bits(5), .dec_frame_width(240), .dec_frame_height(135), .max_hold(0)) u_dut0 (
        .clk(clk), .reset(reset), .s(ifc0.slave));

    function automatic logic [8:0] obs();
        return {ifc.out_valid, ifc.disp_out, ifc.filled_out, ifc.sof_out, ifc.eol_out};
    endfunction

    function automatic logic [8:0] obs0();
        return {ifc0.out_valid, ifc0.disp_out, ifc0.filled_out, ifc0.sof_out, ifc0.eol_out};
    endfunction

    function automatic logic [4:0] wd(input int n);
        return 5'((n * 7 + n / 13) % 32);
    endfunction

    function automatic logic [7:0] wc(input int n);
        return (n % 23 < 11) ? 8'(n % 100) : 8'(100 + n % 156);
    endfunction

    task automatic drive(input logic [4:0] d, input logic [7:0] c);
        ifc.disp_conf_in = {d, c};
        ifc.in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        ifc.in_valid = 1'b1;
        ifc.disp_conf_in = {5'd17, 8'd255};
        ifc.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs() !== 9'd0) begin fails++; $display("FAIL reset_outputs: got %h expected %h", obs(), 9'd0); end
        checks++;
        if (ifc.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", ifc.in_ready); end
        checks++;
        if (obs0() !== 9'd0) begin fails++; $display("FAIL reset_outputs_h0: got %h expected %h", obs0(), 9'd0); end
        apply_reset();
    endtask

    task automatic test_stream();
        logic [4:0] d;
        logic [8:0] exp;
        apply_reset();
        ifc.conf_thresh = 8'd100;
        for (int i = 0; i < 720; i++) begin
            d = 5'((i % 240) % 32);
            drive(d, 8'd200);
            exp = {1'b1, d, 1'b0, i == 0, i % 240 == 239};
            checks++;
            if (obs() !== exp) begin fails++; $display("FAIL stream word %0d: got %h expected %h", i, obs(), exp); end
        end
        ifc.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL stream_drain: out_valid %b expected 0", ifc.out_valid); end
    endtask

    task automatic test_fill_run();
        logic [4:0] in_d [15] = '{7, 3, 3, 3, 9, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
        logic [7:0] in_c [15] = '{200, 50, 50, 50, 200, 50, 50, 50, 50, 50, 50, 50, 50, 50, 50};
        logic [4:0] fd [15]   = '{7, 7, 7, 7, 9, 9, 9, 9, 9, 9, 9, 9, 9, 0, 0};
        logic       ff [15]   = '{0, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        logic [4:0] nd [15]   = '{7, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        logic [8:0] exp, exp0;
        apply_reset();
        ifc.conf_thresh = 8'd100;
        for (int k = 0; k < 15; k++) begin
            drive(in_d[k], in_c[k]);
            exp  = fill_en ? {1'b1, fd[k], ff[k], k == 0, 1'b0} : {1'b1, nd[k], 1'b0, k == 0, 1'b0};
            exp0 = {1'b1, nd[k], 1'b0, k == 0, 1'b0};
            checks++;
            if (obs() !== exp) begin fails++; $display("FAIL fill_run word %0d: got %h expected %h", k, obs(), exp); end
            checks++;
            if (obs0() !== exp0) begin fails++; $display("FAIL fill_run_h0 word %0d: got %h expected %h", k, obs0(), exp0); end
        end
    endtask

    task automatic test_threshold();
        logic [8:0] exp;
        apply_reset();
        ifc.conf_thresh = 8'd100;
        drive(5'd5, 8'd100);
        checks++;
        if (obs() !== {1'b1, 5'd5, 1'b0, 1'b1, 1'b0}) begin fails++; $display("FAIL thresh_equal: got %h expected %h", obs(), {1'b1, 5'd5, 3'b010}); end
        drive(5'd6, 8'd99);
        exp = fill_en ? {1'b1, 5'd5, 3'b100} : {1'b1, 5'd0, 3'b000};
        checks++;
        if (obs() !== exp) begin fails++; $display("FAIL thresh_below: got %h expected %h", obs(), exp); end
        checks++;
        if (obs0() !== {1'b1, 5'd0, 3'b000}) begin fails++; $display("FAIL thresh_below_h0: got %h expected %h", obs0(), {1'b1, 5'd0, 3'b000}); end
        ifc.conf_thresh = 8'd0;
        drive(5'd4, 8'd50);
        exp = fill_en ? {1'b1, 5'd5, 3'b100} : {1'b1, 5'd0, 3'b000};
        checks++;
        if (obs() !== exp) begin fails++; $display("FAIL thresh_latched: got %h expected %h", obs(), exp); end
        drive(5'd8, 8'd255);
        checks++;
        if (obs() !== {1'b1, 5'd8, 3'b000}) begin fails++; $display("FAIL thresh_max_conf: got %h expected %h", obs(), {1'b1, 5'd8, 3'b000}); end
    endtask

    task automatic test_row_boundary();
        apply_reset();
        ifc.conf_thresh = 8'd100;
        for (int i = 0; i < 239; i++) drive(5'd1, 8'd200);
        drive(5'd12, 8'd200);
        checks++;
        if (obs() !== {1'b1, 5'd12, 3'b001}) begin fails++; $display("FAIL row_eol: got %h expected %h", obs(), {1'b1, 5'd12, 3'b001}); end
        drive(5'd3, 8'd50);
        checks++;
        if (obs() !== {1'b1, 5'd0, 3'b000}) begin fails++; $display("FAIL row_no_fill_col0: got %h expected %h", obs(), {1'b1, 5'd0, 3'b000}); end
        drive(5'd4, 8'd50);
        checks++;
        if (obs() !== {1'b1, 5'd0, 3'b000}) begin fails++; $display("FAIL row_no_fill_col1: got %h expected %h", obs(), {1'b1, 5'd0, 3'b000}); end
    endtask

    task automatic test_backpressure();
        localparam int target = frame_words + 8;
        int n = 0, m = 0, cyc = 0, sofs = 0, hc = 0, col, row;
        logic acc_prev = 1'b0, stall_prev = 1'b0, hv = 1'b0, good, fill;
        logic [4:0] lg = '0, ed;
        logic [8:0] saved = '0, now, exp;
        apply_reset();
        ifc.conf_thresh = 8'd100;
        while (m < target && cyc < 80000) begin
            now = obs();
            if (acc_prev) begin
                col = m % 240;
                row = (m / 240) % 135;
                good = wc(m) >= 8'd100;
                fill = fill_en && !good && hv && col != 0 && hc < 8;
                ed = good ? wd(m) : (fill ? lg : 5'd0);
                if (good) begin lg = wd(m); hv = 1'b1; hc = 0; end
                else if (fill) hc++;
                else hv = 1'b0;
                exp = {1'b1, ed, fill, col == 0 && row == 0, col == 239};
                checks++;
                if (now !== exp) begin fails++; $display("FAIL bp word %0d: got %h expected %h", m, now, exp); end
                if (now[1]) sofs++;
                m++;
            end else if (stall_prev) begin
                checks++;
                if (now !== saved) begin fails++; $display("FAIL bp_stall cycle %0d: got %h expected %h", cyc, now, saved); end
            end
            saved = now;
            ifc.out_ready = $urandom_range(0, 3) != 0;
            ifc.in_valid = 1'b1;
            ifc.disp_conf_in = {wd(n), wc(n)};
            #1;
            acc_prev = ifc.in_ready;
            stall_prev = ifc.out_valid && !ifc.out_ready;
            if (acc_prev) n++;
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (m !== target) begin fails++; $display("FAIL bp_timeout: got %0d words expected %0d", m, target); end
        checks++;
        if (sofs !== 2) begin fails++; $display("FAIL bp_sof_count: got %0d expected 2", sofs); end
        ifc.out_ready = 1'b1;
    endtask

    task automatic test_reset_midframe();
        logic [8:0] exp;
        apply_reset();
        ifc.conf_thresh = 8'd100;
        for (int i = 0; i < 5 * 240 + 100; i++) drive(5'd1, 8'd200);
        ifc.conf_thresh = 8'd150;
        ifc.disp_conf_in = {5'd9, 8'd255};
        reset = 1'b1;
        #1;
        checks++;
        if (obs() !== 9'd0) begin fails++; $display("FAIL midreset_async: got %h expected %h", obs(), 9'd0); end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs() !== 9'd0) begin fails++; $display("FAIL midreset_held: got %h expected %h", obs(), 9'd0); end
        reset = 1'b0;
        drive(5'd10, 8'd160);
        checks++;
        if (obs() !== {1'b1, 5'd10, 3'b010}) begin fails++; $display("FAIL midreset_sof: got %h expected %h", obs(), {1'b1, 5'd10, 3'b010}); end
        ifc.conf_thresh = 8'd0;
        drive(5'd11, 8'd140);
        exp = fill_en ? {1'b1, 5'd10, 3'b100} : {1'b1, 5'd0, 3'b000};
        checks++;
        if (obs() !== exp) begin fails++; $display("FAIL midreset_relatch: got %h expected %h", obs(), exp); end
        drive(5'd13, 8'd150);
        checks++;
        if (obs() !== {1'b1, 5'd13, 3'b000}) begin fails++; $display("FAIL midreset_equal: got %h expected %h", obs(), {1'b1, 5'd13, 3'b000}); end
        for (int i = 3; i < 300; i++) begin
            drive(5'(i % 32), 8'd200);
            exp = {1'b1, 5'(i % 32), 1'b0, 1'b0, i == 239};
            checks++;
            if (obs() !== exp) begin fails++; $display("FAIL midreset_word %0d: got %h expected %h", i, obs(), exp); end
        end
    endtask

    initial begin
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b1;
        ifc.conf_thresh = 8'd0;
        ifc.disp_conf_in = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_fill_run();
        test_threshold();
        test_row_boundary();
        test_backpressure();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
